// File: rtl/ddr_rd_pkg.sv
// rtl/ddr_rd_pkg.sv - shared DDR read-path state encoding and beat derivation
package ddr_rd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } rd_state_e;

    localparam int DEF_DDR_W  = 64;
    localparam int DEF_DATA_W = 16;

    function automatic int calc_beats(input int ddr_w, input int data_w);
        return ddr_w / data_w;
    endfunction

    // The unpacker only supports whole beats per DDR word and up to 8 loaders.
    function automatic bit cfg_ok(input int ddr_w, input int data_w, input int num_ch);
        return (data_w > 0) && (ddr_w >= data_w) && ((ddr_w % data_w) == 0)
            && (num_ch >= 1) && (num_ch <= 8);
    endfunction

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ddr_rd_mux_rr_arbiter.sv
// rtl/ddr_rd_mux_rr_arbiter.sv - round-robin requester select with pointer update
module rr_arbiter
    import ddr_rd_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int PW     = idx_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req_i,
    input  logic              update_i,
    output logic              valid_o,
    output logic [PW-1:0]     idx_o,
    output logic [NUM_CH-1:0] gnt_o
);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW-1:0] cand;

    // Scan starting at the pointer; the first requester found wins.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            cand = PW'((int'(ptr_q) + k) % NUM_CH);
            if (!valid_o && req_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

    always_comb begin
        gnt_o = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            gnt_o[c] = valid_o && (idx_o == PW'(c));
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (update_i && valid_o) begin
            ptr_d = (idx_o == PW'(NUM_CH - 1)) ? '0 : idx_o + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/ddr_rd_mux.sv
// rtl/ddr_rd_mux.sv - multi-channel DDR read front end: arbitrate, issue burst, unpack to owner
module ddr_rd_mux
    import ddr_rd_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int WIDTH_ddr_addr = 25,
    parameter int DDR_W          = DEF_DDR_W,
    parameter int DATA_W         = DEF_DATA_W
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_CH-1:0]                ch_req,
    input  logic [NUM_CH*WIDTH_ddr_addr-1:0] ch_addr,
    input  logic [NUM_CH*WIDTH_ddr_addr-1:0] ch_len,
    output logic [NUM_CH-1:0]                ch_gnt,
    output logic [DATA_W-1:0]                ch_data,
    output logic [NUM_CH-1:0]                ch_en,
    output logic [NUM_CH-1:0]                ch_done,
    output logic                             ddr_req,
    output logic [WIDTH_ddr_addr-1:0]        ddr_addr,
    output logic [WIDTH_ddr_addr-1:0]        ddr_len,
    input  logic                             ddr_ack,
    input  logic [DDR_W-1:0]                 ddr_rdata,
    input  logic                             ddr_rvalid,
    output logic                             ddr_rready,
    output logic                             err_stray
);

    localparam int AW    = WIDTH_ddr_addr;
    localparam int BEATS = calc_beats(DDR_W, DATA_W);
    localparam int PW    = idx_w(NUM_CH);
    localparam int BW    = idx_w(BEATS);

    if (!cfg_ok(DDR_W, DATA_W, NUM_CH)) begin : g_bad_cfg
        $error("ddr_rd_mux: DDR_W must be a multiple of DATA_W and NUM_CH in 1..8");
    end

    rd_state_e         state_q, state_d;
    logic [PW-1:0]     owner_q, owner_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [AW-1:0]     len_q, len_d;
    logic [NUM_CH-1:0] gnt_q, gnt_d;
    logic [DDR_W-1:0]  word_q, word_d;
    logic              full_q, full_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic [AW-1:0]     words_q, words_d;
    logic              err_q, err_d;

    logic              arb_valid;
    logic [PW-1:0]     arb_idx;
    logic [NUM_CH-1:0] arb_gnt;
    logic [AW-1:0]     sel_addr;
    logic [AW-1:0]     sel_len;
    logic              last_beat;
    logic              accept;
    logic [NUM_CH-1:0] owner_oh;
    logic [DATA_W-1:0] beat_data;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .PW     (PW)
    ) u_arb (
        .clk      (clk),
        .rst_n    (reset),
        .req_i    (ch_req),
        .update_i (state_q == ST_IDLE),
        .valid_o  (arb_valid),
        .idx_o    (arb_idx),
        .gnt_o    (arb_gnt)
    );

    always_comb begin
        sel_addr = '0;
        sel_len  = '0;
        owner_oh = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (arb_idx == PW'(c)) begin
                sel_addr = ch_addr[c*AW +: AW];
                sel_len  = ch_len[c*AW +: AW];
            end
            owner_oh[c] = (owner_q == PW'(c));
        end
    end

    always_comb begin
        beat_data = '0;
        for (int b = 0; b < BEATS; b++) begin
            if (beat_q == BW'(b)) begin
                beat_data = word_q[b*DATA_W +: DATA_W];
            end
        end
    end

    // A new word may land while the previous one shows its last beat, so
    // streaming runs one word per BEATS cycles; nothing beyond len is taken.
    assign last_beat  = full_q && (beat_q == BW'(BEATS - 1));
    assign ddr_rready = (state_q == ST_DATA) && (words_q != len_q) && (!full_q || last_beat);
    assign accept     = ddr_rvalid && ddr_rready;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        len_d   = len_q;
        gnt_d   = '0;
        word_d  = word_q;
        full_d  = full_q;
        beat_d  = beat_q;
        words_d = words_q;
        err_d   = err_q;

        if (ddr_rvalid && (state_q != ST_DATA)) begin
            err_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    gnt_d   = arb_gnt;
                    owner_d = arb_idx;
                    addr_d  = sel_addr;
                    len_d   = sel_len;
                    words_d = '0;
                    full_d  = 1'b0;
                    beat_d  = '0;
                    state_d = (sel_len == '0) ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                if (ddr_ack) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (full_q) begin
                    if (last_beat) begin
                        full_d = 1'b0;
                        beat_d = '0;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
                if (accept) begin
                    word_d  = ddr_rdata;
                    full_d  = 1'b1;
                    beat_d  = '0;
                    words_d = words_q + 1'b1;
                end
                if (last_beat && (words_q == len_q)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            gnt_q   <= '0;
            word_q  <= '0;
            full_q  <= 1'b0;
            beat_q  <= '0;
            words_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            gnt_q   <= gnt_d;
            word_q  <= word_d;
            full_q  <= full_d;
            beat_q  <= beat_d;
            words_q <= words_d;
            err_q   <= err_d;
        end
    end

    assign ch_gnt    = gnt_q;
    assign ch_en     = full_q ? owner_oh : '0;
    assign ch_data   = full_q ? beat_data : '0;
    assign ch_done   = (state_q == ST_DONE) ? owner_oh : '0;
    assign ddr_req   = (state_q == ST_REQ);
    assign ddr_addr  = addr_q;
    assign ddr_len   = len_q;
    assign err_stray = err_q;

endmodule

// File: doc/ddr_rd_mux.md
Name: ddr_rd_mux

Overview:
- Multi-channel DDR read front end that replaces the single-requester DL-to-DDR path.
- NUM_CH loaders raise read requests of (addr, len). The block arbitrates round-robin and issues one DDR burst at a time.
- Returned DDR_W-bit words are unpacked LSB-first into DATA_W-bit beats, which are steered only to the channel that owns the burst.
- Sits between the loader instances (DL and successors) and the DDR controller read port.

Parameters:
- NUM_CH, 4: number of requesting channels, 1..8.
- WIDTH_ddr_addr, 25: DDR word-address width; also the burst length width.
- DDR_W, 64: DDR read data width.
- DATA_W, 16: channel beat width. DDR_W must be an integer multiple of DATA_W.
- BEATS, DDR_W/DATA_W (4 at defaults): derived; beats per DDR word.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-low reset.
- ch_req  in  NUM_CH  per-channel level request; held until ch_gnt.
- ch_addr  in  NUM_CH*WIDTH_ddr_addr  start word address; channel i at slice i.
- ch_len  in  NUM_CH*WIDTH_ddr_addr  burst length in DDR words.
- ch_gnt  out  NUM_CH  one-hot, 1-cycle pulse; request latched.
- ch_data  out  DATA_W  beat data, broadcast to all channels.
- ch_en  out  NUM_CH  one-hot beat strobe to the owning channel.
- ch_done  out  NUM_CH  one-hot, 1-cycle pulse; burst complete.
- ddr_req  out  1  level; held from grant until ddr_ack.
- ddr_addr  out  WIDTH_ddr_addr  latched burst address; stable while ddr_req is high.
- ddr_len  out  WIDTH_ddr_addr  latched burst length; stable while ddr_req is high.
- ddr_ack  in  1  controller accepted the request.
- ddr_rdata  in  DDR_W  read word.
- ddr_rvalid  in  1  read word valid.
- ddr_rready  out  1  block can accept a word.
- err_stray  out  1  sticky; ddr_rvalid arrived while no burst was outstanding.

Behaviour:
- Reset values: all outputs 0 and FSM in IDLE. Round-robin pointer resets to channel 0 and word/beat counters clear.
- Reset asserted mid-burst: everything returns to reset values immediately and ddr_req drops. Words in flight are discarded.
- FSM IDLE:
  - If any ch_req is high, select the first requester at or after rr_ptr.
  - Next cycle: pulse ch_gnt[i], latch addr/len/owner, set rr_ptr=i+1 mod NUM_CH.
  - If len!=0, go to REQ. If len==0, skip DDR and go to DONE.
- FSM REQ:
  - ddr_req is high (asserted the cycle after the grant decision).
  - On ddr_ack: drop ddr_req the next cycle and go to DATA.
- FSM DATA:
  - A word is accepted when ddr_rvalid && ddr_rready. It loads the unpack register, and words_rcvd increments.
  - Beats emit on cycles t+1..t+BEATS, bits [DATA_W-1:0] first, ch_en[owner]=1 on each.
  - ddr_rready = unpack register empty, OR the current cycle is its last beat. This allows gapless streaming: 1 word per BEATS cycles.
  - The channel side has no backpressure.
  - After the last beat of word number len, go to DONE.
- FSM DONE: pulse ch_done[owner] for 1 cycle, return to IDLE, and re-arbitrate the next cycle.
- Stray data:
  - ddr_rvalid in IDLE, REQ, or DONE is not accepted and sets err_stray, which clears only on reset.
  - ddr_rready is 0 outside DATA.
- ddr_rvalid in the same cycle as ddr_ack: ignored. Data is only accepted from the cycle after the ack.
- A channel that drops ch_req before its grant withdraws its request. Arbitration samples ch_req only in IDLE.
- Latency from ch_req to first ch_en: 2 cycles plus the controller ack latency plus 1 cycle after word acceptance.
- Counters are WIDTH_ddr_addr wide. ddr_addr is not incremented internally; the controller walks the burst. The maximum len of 2^WIDTH_ddr_addr-1 must complete without wrap.

Decomposition:
- Shared package ddr_rd_pkg: FSM state enum (IDLE, REQ, DATA, DONE) and the BEATS derivation/check constant, reused by the loaders.
- One sub-module, rr_arbiter: NUM_CH-wide round-robin priority select with a pointer update input. The rest is inline.

Test Plan:
- Single channel: ch_req[0], addr=0x100, len=2; ddr_ack 3 cycles later; words 0x0004_0003_0002_0001 and 0x0008_0007_0006_0005 back-to-back → ch_en[0] for 8 consecutive beats with data 1..8, one ch_done[0] pulse, ddr_rready never idles between words.
- All 4 channels request at once, each with len=1 → grants in order 0,1,2,3; ddr_addr matches each channel; no ch_en on a non-owner channel.
- Channel 2 requests again right after its grant, while channel 1 has a pending request → channel 1 is served before channel 2 is served again.
- len=0 on channel 3 → ch_gnt[3], then ch_done[3] without ddr_req ever asserting.
- ddr_rvalid pulsed in IDLE → no ch_en and err_stray=1, still 1 after the next normal burst.
- reset asserted after 2 beats of a len=4 burst → next clock ddr_req=0, ch_en=0, FSM in IDLE; a fresh len=1 request then completes normally.
